// File: rtl/lmeu_pkg.sv
// rtl/lmeu_pkg.sv - shared types, opcodes and control decode for the main control FSM
// Purpose: state_t enum, opcode and alu_op constants, and the per-state control word.
// Ports: none (package).
package lmeu_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      EXEC_R,
      EXEC_SPC,
      WB_R,
      WB_SPC,
      EXEC_ADDR,
      MEM_RD,
      MEM_WR,
      WB_MEM,
      BRANCH,
      TRAP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_SPC   = 6'b111111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_CMP   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_SPC   = 2'b11;

   // Level outputs that depend only on the state. ir_write/pc_write are not
   // here: they fire on the accepted fetch cycle, not for the whole FETCH stay.
   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       pc_branch;
      logic       imem_req;
      logic       dmem_rd;
      logic       dmem_wr;
      logic       reg_write;
      logic       trap;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH:     c.imem_req = 1'b1;
         EXEC_R:    c.alu_op = ALUOP_FUNCT;
         WB_R:      begin c.alu_op = ALUOP_FUNCT; c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         EXEC_SPC:  c.alu_op = ALUOP_SPC;
         WB_SPC:    begin c.alu_op = ALUOP_SPC; c.reg_write = 1'b1; c.reg_dst = 1'b1; end
         EXEC_ADDR: begin c.alu_op = ALUOP_ADD; c.alu_src = 1'b1; end
         MEM_RD:    begin c.alu_op = ALUOP_ADD; c.alu_src = 1'b1; c.dmem_rd = 1'b1; end
         MEM_WR:    begin c.alu_op = ALUOP_ADD; c.alu_src = 1'b1; c.dmem_wr = 1'b1; end
         WB_MEM:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         BRANCH:    begin c.alu_op = ALUOP_CMP; c.pc_branch = 1'b1; end
         TRAP:      c.trap = 1'b1;
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// rtl/main_control_fsm_if.sv - handshake and datapath-control bundle of the main control FSM
// Purpose: groups opcode/ready inputs and all control outputs.
// Ports: master = control FSM (drives controls), slave = datapath/memory side.
interface main_control_fsm_if;
   logic [5:0] opcode;
   logic       imem_ready;
   logic       dmem_ready;
   logic [1:0] alu_op;
   logic       alu_src;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       pc_write;
   logic       pc_branch;
   logic       ir_write;
   logic       imem_req;
   logic       dmem_rd;
   logic       dmem_wr;
   logic       reg_write;
   logic       trap;

   modport master (
      input  opcode, imem_ready, dmem_ready,
      output alu_op, alu_src, reg_dst, mem_to_reg, pc_write, pc_branch,
             ir_write, imem_req, dmem_rd, dmem_wr, reg_write, trap
   );

   modport slave (
      output opcode, imem_ready, dmem_ready,
      input  alu_op, alu_src, reg_dst, mem_to_reg, pc_write, pc_branch,
             ir_write, imem_req, dmem_rd, dmem_wr, reg_write, trap
   );
endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - wait-cycle counter for memory handshakes
// Purpose: counts cycles spent waiting on a ready; expired marks the last allowed cycle.
// Ports: clk, rst_n (async active-low), clear (restart at 0), enable (count one wait
//        cycle), expired (count == MEM_TIMEOUT-1).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + W'(1);
      end
   end

   assign expired = (count == LAST);
endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle main control unit (fetch/decode/execute/memory/writeback)
// Purpose: sequences each instruction and drives ALU op, datapath enables and memory strobes.
// Ports: clk, rst_n (async active-low), bus (main_control_fsm_if.master): opcode,
//        imem_ready, dmem_ready in; alu_op, alu_src, reg_dst, mem_to_reg, pc_write,
//        pc_branch, ir_write, imem_req, dmem_rd, dmem_wr, reg_write, trap out.
module main_control_fsm
   import lmeu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   main_control_fsm_if.master  bus
);
   state_t state;
   state_t next_state;
   ctrl_t  ctrl;
   logic   waiting;
   logic   ready;
   logic   expired;
   logic   fetch_done;

   // A fetch only counts as waiting once imem_req is actually out; the
   // registered request is low in the first cycle after reset.
   always_comb begin
      waiting = 1'b0;
      ready   = 1'b0;
      case (state)
         FETCH:          begin waiting = ctrl.imem_req; ready = bus.imem_ready; end
         MEM_RD, MEM_WR: begin waiting = 1'b1;          ready = bus.dmem_ready; end
         default:        ;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         FETCH: begin
            if (waiting && ready)        next_state = DECODE;
            else if (waiting && expired) next_state = TRAP;
         end
         DECODE: begin
            case (bus.opcode)
               OP_RTYPE:     next_state = EXEC_R;
               OP_LW, OP_SW: next_state = EXEC_ADDR;
               OP_BEQ:       next_state = BRANCH;
               OP_SPC:       next_state = EXEC_SPC;
               default:      next_state = TRAP;
            endcase
         end
         EXEC_R:   next_state = WB_R;
         WB_R:     next_state = FETCH;
         EXEC_SPC: next_state = WB_SPC;
         WB_SPC:   next_state = FETCH;
         EXEC_ADDR: begin
            if (bus.opcode == OP_LW)      next_state = MEM_RD;
            else if (bus.opcode == OP_SW) next_state = MEM_WR;
            else                          next_state = TRAP;
         end
         MEM_RD: begin
            if (ready)        next_state = WB_MEM;
            else if (expired) next_state = TRAP;
         end
         MEM_WR: begin
            if (ready)        next_state = FETCH;
            else if (expired) next_state = TRAP;
         end
         WB_MEM:  next_state = FETCH;
         BRANCH:  next_state = FETCH;
         TRAP:    next_state = TRAP;
         default: next_state = TRAP;
      endcase
   end

   // Any state change restarts the count, so each wait state is entered at 0.
   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (next_state != state),
      .enable  (waiting && !ready),
      .expired (expired)
   );

   // Outputs are registered from the next state so they line up with the
   // state register while remaining glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         ctrl  <= '0;
      end else begin
         state <= next_state;
         ctrl  <= decode_ctrl(next_state);
      end
   end

   // IR/PC load on the single cycle the fetch is accepted.
   assign fetch_done = (state == FETCH) && ctrl.imem_req && bus.imem_ready;

   assign bus.ir_write   = fetch_done;
   assign bus.pc_write   = fetch_done;
   assign bus.alu_op     = ctrl.alu_op;
   assign bus.alu_src    = ctrl.alu_src;
   assign bus.reg_dst    = ctrl.reg_dst;
   assign bus.mem_to_reg = ctrl.mem_to_reg;
   assign bus.pc_branch  = ctrl.pc_branch;
   assign bus.imem_req   = ctrl.imem_req;
   assign bus.dmem_rd    = ctrl.dmem_rd;
   assign bus.dmem_wr    = ctrl.dmem_wr;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.trap       = ctrl.trap;
endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - self-checking bench for main_control_fsm
module tb_main_control_fsm;
   localparam int TMO = 16;

   localparam logic [5:0] RT  = 6'b000000;
   localparam logic [5:0] LW  = 6'b100011;
   localparam logic [5:0] SW  = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100;
   localparam logic [5:0] SPC = 6'b111111;

   // Expected-output vector bits; alu_op occupies [1:0].
   localparam logic [12:0] A_ADD = 13'd0;
   localparam logic [12:0] A_CMP = 13'd1;
   localparam logic [12:0] A_FN  = 13'd2;
   localparam logic [12:0] A_SP  = 13'd3;
   localparam logic [12:0] ASRC  = 13'h004;
   localparam logic [12:0] RDST  = 13'h008;
   localparam logic [12:0] M2R   = 13'h010;
   localparam logic [12:0] PCW   = 13'h020;
   localparam logic [12:0] PCB   = 13'h040;
   localparam logic [12:0] IRW   = 13'h080;
   localparam logic [12:0] IREQ  = 13'h100;
   localparam logic [12:0] DRD   = 13'h200;
   localparam logic [12:0] DWR   = 13'h400;
   localparam logic [12:0] RW    = 13'h800;
   localparam logic [12:0] TRP   = 13'h1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   main_control_fsm_if bus();

   main_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [12:0] outs;
   assign outs = {bus.trap, bus.reg_write, bus.dmem_wr, bus.dmem_rd, bus.imem_req,
                  bus.ir_write, bus.pc_branch, bus.pc_write, bus.mem_to_reg,
                  bus.reg_dst, bus.alu_src, bus.alu_op};

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [5:0]  op;
      logic        ir;
      logic        dr;
      logic [12:0] exp;
      string       tag;
   } step_t;

   step_t q[$];
   bit    trapped;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic add(input logic [5:0] op, input logic ir, input logic dr,
                      input logic [12:0] e, input string tag);
      step_t s;
      s.op = op; s.ir = ir; s.dr = dr; s.exp = e; s.tag = tag;
      q.push_back(s);
   endtask

   // Expected per-cycle trace of one instruction, from the instruction-class
   // latencies and the wait/timeout rules. di/dd = non-ready cycles before the
   // imem/dmem ready; TMO or more means the access never completes.
   task automatic gen_instr(input logic [5:0] op, input int di, input int dd);
      string t;
      logic [12:0] mem;
      t = $sformatf("op%b", op);
      for (int k = 0; k < ((di < TMO) ? di : TMO); k++)
         add(op, 1'b0, rb(), IREQ, {t, "_fwait"});
      if (di >= TMO) begin
         trapped = 1'b1;
         return;
      end
      add(op, 1'b1, rb(), IREQ | IRW | PCW, {t, "_fetch"});
      add(op, rb(), rb(), 13'h0, {t, "_decode"});
      case (op)
         RT: begin
            add(op, rb(), rb(), A_FN, {t, "_exec"});
            add(op, rb(), rb(), A_FN | RW | RDST, {t, "_wb"});
         end
         SPC: begin
            add(op, rb(), rb(), A_SP, {t, "_exec"});
            add(op, rb(), rb(), A_SP | RW | RDST, {t, "_wb"});
         end
         BEQ: add(op, rb(), rb(), A_CMP | PCB, {t, "_branch"});
         LW, SW: begin
            mem = (op == LW) ? DRD : DWR;
            add(op, rb(), rb(), A_ADD | ASRC, {t, "_addr"});
            for (int k = 0; k < ((dd < TMO) ? dd : TMO); k++)
               add(op, rb(), 1'b0, mem | ASRC, {t, "_dwait"});
            if (dd >= TMO) begin
               trapped = 1'b1;
            end else begin
               add(op, rb(), 1'b1, mem | ASRC, {t, "_mem"});
               if (op == LW) add(op, rb(), rb(), M2R | RW, {t, "_wb"});
            end
         end
         default: trapped = 1'b1;
      endcase
   endtask

   task automatic run_queue(input int max);
      int n = 0;
      while (q.size() > 0 && n < max) begin
         step_t s;
         s = q.pop_front();
         @(posedge clk);
         #1;
         bus.opcode     = s.op;
         bus.imem_ready = s.ir;
         bus.dmem_ready = s.dr;
         @(negedge clk);
         check(s.tag, {3'b000, outs}, {3'b000, s.exp});
         n++;
      end
      q.delete();
   endtask

   // Trap must hold regardless of readies and opcode, then reset clears it.
   task automatic finish_trap_and_reset();
      for (int k = 0; k < 4; k++)
         add(6'($urandom), 1'b1, 1'b1, TRP, "trap_sticky");
      run_queue(1000);
      do_reset();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      @(negedge clk);
      check("reset_outs", {3'b000, outs}, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      trapped = 1'b0;
   endtask

   task automatic do_instr(input logic [5:0] op, input int di, input int dd);
      gen_instr(op, di, dd);
      run_queue(1000);
      if (trapped) finish_trap_and_reset();
   endtask

   initial begin
      logic [5:0] op;
      int r, di, dd;
      bus.opcode = '0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      trapped = 1'b0;
      do_reset();

      do_instr(RT, 0, 0);
      do_instr(LW, 0, 3);
      do_instr(SW, 2, 1);
      do_instr(BEQ, 1, 0);
      do_instr(SPC, 0, 0);
      do_instr(RT, TMO - 1, 0);
      do_instr(SW, 0, TMO - 1);

      // Reset while a load is waiting: requests drop at once, no writeback.
      gen_instr(LW, 0, 10);
      run_queue(5);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_dmem_rd", {15'h0, bus.dmem_rd}, 16'h0);
      check("rst_async_outs", {3'b000, outs}, 16'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      trapped = 1'b0;
      do_instr(RT, 0, 0);

      do_instr(6'b001111, 0, 0);
      do_instr(RT, TMO, 0);
      do_instr(LW, 1, TMO);

      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 19);
         if (r < 4)       op = RT;
         else if (r < 8)  op = LW;
         else if (r < 12) op = SW;
         else if (r < 15) op = BEQ;
         else if (r < 18) op = SPC;
         else begin
            do op = 6'($urandom);
            while (op == RT || op == LW || op == SW || op == BEQ || op == SPC);
         end
         di = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO) : $urandom_range(0, 3);
         dd = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO) : $urandom_range(0, 3);
         do_instr(op, di, dd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
